// File: rtl/rec_play_ctrl_pkg.sv
// Shared constants for the note record/replay sequencer: state encodings,
// note codes and default widths.
package rec_play_ctrl_pkg;

  localparam int ADDR_W_DEF   = 7;
  localparam int DUR_W_DEF    = 10;
  localparam int NOTE_W_DEF   = 3;
  localparam int TICK_DIV_DEF = 1000000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REC   = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  typedef enum logic [2:0] {
    NOTE_SPACE = 3'd0,
    NOTE_DO    = 3'd1,
    NOTE_RE    = 3'd2,
    NOTE_MI    = 3'd3,
    NOTE_FA    = 3'd4,
    NOTE_SOL   = 3'd5,
    NOTE_LA    = 3'd6,
    NOTE_SI    = 3'd7
  } note_e;

endpackage

// File: rtl/rec_play_ctrl_tick_gen.sv
// Free-running tick divider; clr restarts the count so the next tick lands
// exactly TICK_DIV cycles later.
module rec_play_ctrl_tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Divider counter, wrapping at TICK_DIV-1.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign tick = (r_cnt == CNT_LAST) & ~clr;

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/replay sequencer: run-length encodes the live note stream into the
// external note RAM and replays it tick by tick.
module rec_play_ctrl
  import rec_play_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  parameter int NOTE_W   = NOTE_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     btn_rec,
  input  logic                     btn_play,
  input  logic                     btn_stop,
  input  logic                     btn_clear,
  input  logic [NOTE_W-1:0]        note_in,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_wr_addr,
  output logic [NOTE_W+DUR_W-1:0]  mem_wr_data,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [NOTE_W+DUR_W-1:0]  mem_rd_data,
  output logic [NOTE_W-1:0]        note_out,
  output logic [1:0]               state_out,
  output logic [ADDR_W:0]          len_out,
  output logic                     full
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;

  logic [1:0]              r_state;
  logic [LEN_W-1:0]        r_wr_ptr;
  logic [LEN_W-1:0]        r_rd_ptr;
  logic [LEN_W-1:0]        r_len;
  logic                    r_full;
  logic                    r_run_valid;
  logic [NOTE_W-1:0]       r_cur_note;
  logic [DUR_W-1:0]        r_dur;
  logic [DUR_W-1:0]        r_remain;
  logic                    r_fetch_wait;
  logic [NOTE_W-1:0]       r_note_out;
  logic                    r_mem_wr_en;
  logic [ADDR_W-1:0]       r_mem_wr_addr;
  logic [NOTE_W+DUR_W-1:0] r_mem_wr_data;
  logic [ADDR_W-1:0]       r_mem_rd_addr;

  logic                    w_tick;
  logic                    w_tick_clr;
  logic                    w_idle;
  logic                    w_go_rec;
  logic                    w_go_play;
  logic                    w_rec_extend;
  logic                    w_wr_last;
  logic [LEN_W-1:0]        w_rd_next;
  logic [NOTE_W-1:0]       w_rd_note;
  logic [DUR_W-1:0]        w_rd_dur;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_go_rec     = w_idle & ~btn_clear & btn_rec;
  assign w_go_play    = w_idle & ~btn_clear & ~btn_rec & btn_play & (r_len != '0);
  assign w_tick_clr   = w_go_rec | w_go_play;
  assign w_rec_extend = r_run_valid & (note_in == r_cur_note) & (r_dur != DUR_MAX);
  assign w_wr_last    = (r_wr_ptr == LAST_IDX);
  assign w_rd_next    = r_rd_ptr + LEN_ONE;
  assign w_rd_note    = mem_rd_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rd_dur     = mem_rd_data[DUR_W-1:0];

  rec_play_ctrl_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (w_tick_clr),
    .tick    (w_tick)
  );

  // Mode FSM with record encoder and replay sequencer.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_len         <= '0;
      r_full        <= 1'b0;
      r_run_valid   <= 1'b0;
      r_cur_note    <= '0;
      r_dur         <= '0;
      r_remain      <= '0;
      r_fetch_wait  <= 1'b0;
      r_note_out    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_mem_rd_addr <= '0;
    end else begin
      r_mem_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_note_out <= '0;
          if (btn_clear) begin
            r_len    <= '0;
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
          end else if (btn_rec) begin
            r_wr_ptr    <= '0;
            r_len       <= '0;
            r_full      <= 1'b0;
            r_run_valid <= 1'b0;
            r_state     <= ST_REC;
          end else if (w_go_play) begin
            r_rd_ptr      <= '0;
            r_mem_rd_addr <= '0;
            r_fetch_wait  <= 1'b0;
            r_state       <= ST_FETCH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REC: begin
          r_note_out <= note_in;
          if (btn_stop) begin
            if (r_run_valid) begin
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_addr <= r_wr_ptr[ADDR_W-1:0];
              r_mem_wr_data <= {r_cur_note, r_dur};
              r_wr_ptr      <= r_wr_ptr + LEN_ONE;
              r_len         <= r_wr_ptr + LEN_ONE;
              r_full        <= w_wr_last;
            end else begin
              r_len <= r_wr_ptr;
            end
            r_run_valid <= 1'b0;
            r_note_out  <= '0;
            r_state     <= ST_IDLE;
          end else if (w_tick) begin
            if (!r_run_valid) begin
              r_cur_note  <= note_in;
              r_dur       <= DUR_ONE;
              r_run_valid <= 1'b1;
            end else if (w_rec_extend) begin
              r_dur <= r_dur + DUR_ONE;
            end else begin
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_addr <= r_wr_ptr[ADDR_W-1:0];
              r_mem_wr_data <= {r_cur_note, r_dur};
              // Last slot written: stop here, the run just started is dropped.
              if (w_wr_last) begin
                r_full      <= 1'b1;
                r_len       <= LEN_FULL;
                r_run_valid <= 1'b0;
                r_note_out  <= '0;
                r_state     <= ST_IDLE;
              end else begin
                r_wr_ptr   <= r_wr_ptr + LEN_ONE;
                r_cur_note <= note_in;
                r_dur      <= DUR_ONE;
              end
            end
          end else begin
            r_state <= ST_REC;
          end
        end
        ST_FETCH: begin
          if (btn_stop) begin
            r_note_out <= '0;
            r_state    <= ST_IDLE;
          end else if (!r_fetch_wait) begin
            r_fetch_wait <= 1'b1;
          end else begin
            r_note_out   <= w_rd_note;
            r_remain     <= (w_rd_dur == '0) ? DUR_ONE : w_rd_dur;
            r_fetch_wait <= 1'b0;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (btn_stop) begin
            r_note_out <= '0;
            r_state    <= ST_IDLE;
          end else if (w_tick) begin
            if (r_remain > DUR_ONE) begin
              r_remain <= r_remain - DUR_ONE;
            end else if (w_rd_next == r_len) begin
              r_note_out <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_rd_ptr      <= w_rd_next;
              r_mem_rd_addr <= w_rd_next[ADDR_W-1:0];
              r_fetch_wait  <= 1'b0;
              r_state       <= ST_FETCH;
            end
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_note_out <= '0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign mem_rd_addr = r_mem_rd_addr;
  assign note_out    = r_note_out;
  assign state_out   = r_state;
  assign len_out     = r_len;
  assign full        = r_full;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Scoreboard bench: two sequencer instances (wide and tiny RAM) share one
// stimulus stream; expectations come from a run-length model of the tape.
module tb_rec_play_ctrl;

  localparam int P_REC = 1, P_PLAY = 2, P_STOP = 4, P_CLEAR = 8;

  typedef struct { int note; int dur; } ent_t;
  typedef struct { int addr; int data; } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_rec = 1'b0, btn_play = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0;
  logic [2:0] note_in = 3'd0;

  logic        a_wr_en, a_full;
  logic [6:0]  a_wr_addr, a_rd_addr;
  logic [12:0] a_wr_data, a_rd_data;
  logic [2:0]  a_note;
  logic [1:0]  a_state;
  logic [7:0]  a_len;

  logic        b_wr_en, b_full;
  logic [1:0]  b_wr_addr, b_rd_addr;
  logic [5:0]  b_wr_data, b_rd_data;
  logic [2:0]  b_note;
  logic [1:0]  b_state;
  logic [2:0]  b_len;

  logic [12:0] ram_a [0:127];
  logic [5:0]  ram_b [0:3];

  int   errors = 0;
  int   checks = 0;
  int   tape[$];
  ent_t ents_tmp[$];
  ent_t ents_a[$];
  wr_t  exp_wr_a[$];
  wr_t  exp_wr_b[$];
  int   exp_play[$];
  int   wr_seen_a = 0;
  int   wr_seen_b = 0;
  int   play_done_cnt = 0;
  logic play_armed = 1'b0;

  always #5 clk = ~clk;

  rec_play_ctrl #(.ADDR_W(7), .DUR_W(10), .NOTE_W(3), .TICK_DIV(4)) u_dut_a (
    .sys_clk(clk), .rst_n(rst_n), .btn_rec(btn_rec), .btn_play(btn_play),
    .btn_stop(btn_stop), .btn_clear(btn_clear), .note_in(note_in),
    .mem_wr_en(a_wr_en), .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data),
    .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data), .note_out(a_note),
    .state_out(a_state), .len_out(a_len), .full(a_full)
  );

  rec_play_ctrl #(.ADDR_W(2), .DUR_W(3), .NOTE_W(3), .TICK_DIV(4)) u_dut_b (
    .sys_clk(clk), .rst_n(rst_n), .btn_rec(btn_rec), .btn_play(btn_play),
    .btn_stop(btn_stop), .btn_clear(btn_clear), .note_in(note_in),
    .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
    .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data), .note_out(b_note),
    .state_out(b_state), .len_out(b_len), .full(b_full)
  );

  always @(posedge clk) begin
    if (a_wr_en) ram_a[a_wr_addr] <= a_wr_data;
    a_rd_data <= ram_a[a_rd_addr];
    if (b_wr_en) ram_b[b_wr_addr] <= b_wr_data;
    b_rd_data <= ram_b[b_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Run-length model of the global tape with duration cap and capacity.
  task automatic rle(input int durmax, input int depth);
    int last;
    ents_tmp.delete();
    foreach (tape[i]) begin
      last = ents_tmp.size() - 1;
      if (last >= 0 && ents_tmp[last].note == tape[i] && ents_tmp[last].dur < durmax)
        ents_tmp[last].dur = ents_tmp[last].dur + 1;
      else
        ents_tmp.push_back('{note: tape[i], dur: 1});
    end
    while (ents_tmp.size() > depth) void'(ents_tmp.pop_back());
  endtask

  task automatic pulse(input int which);
    btn_rec   = which[0];
    btn_play  = which[1];
    btn_stop  = which[2];
    btn_clear = which[3];
    @(negedge clk);
    btn_rec = 1'b0; btn_play = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
  endtask

  task automatic do_record();
    int nb;
    rle(1023, 128);
    ents_a = ents_tmp;
    foreach (ents_a[i]) exp_wr_a.push_back('{addr: i, data: ents_a[i].note * 1024 + ents_a[i].dur});
    rle(7, 4);
    nb = ents_tmp.size();
    foreach (ents_tmp[i]) exp_wr_b.push_back('{addr: i, data: ents_tmp[i].note * 8 + ents_tmp[i].dur});
    pulse(P_REC);
    foreach (tape[i]) begin
      note_in = 3'(tape[i]);
      repeat (4) @(negedge clk);
    end
    pulse(P_STOP);
    repeat (3) @(negedge clk);
    chk("a_len", a_len, ents_a.size());
    chk("a_full", a_full, ents_a.size() == 128);
    chk("a_state_after_rec", a_state, 0);
    chk("a_writes_drained", exp_wr_a.size(), 0);
    chk("b_len", b_len, nb);
    chk("b_full", b_full, nb == 4);
    chk("b_state_after_rec", b_state, 0);
    chk("b_writes_drained", exp_wr_b.size(), 0);
    exp_wr_a.delete();
    exp_wr_b.delete();
  endtask

  task automatic do_play();
    int d0, lim;
    lim = 0;
    foreach (ents_a[i]) begin
      for (int k = 0; k < ents_a[i].dur; k++) begin
        exp_play.push_back(ents_a[i].note);
        lim++;
      end
    end
    d0 = play_done_cnt;
    play_armed = 1'b1;
    pulse(P_PLAY);
    play_armed = 1'b0;
    for (int c = 0; c < 4 * lim + 20 && play_done_cnt == d0; c++) @(negedge clk);
    checks++;
    if (play_done_cnt == d0) begin
      errors++;
      $display("FAIL play_timeout: %0d ticks still queued, expected playback to finish", exp_play.size());
      exp_play.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Write monitors: every RAM strobe must match the next expected entry.
  initial begin : wr_mon_a
    wr_t w;
    forever begin
      @(negedge clk);
      if (a_wr_en === 1'b1) begin
        wr_seen_a++;
        if (exp_wr_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_write: got addr=%0d data=%0h, expected no write", a_wr_addr, a_wr_data);
        end else begin
          w = exp_wr_a.pop_front();
          chk("a_wr_addr", a_wr_addr, w.addr);
          chk("a_wr_data", a_wr_data, w.data);
        end
      end
    end
  end

  initial begin : wr_mon_b
    wr_t w;
    forever begin
      @(negedge clk);
      if (b_wr_en === 1'b1) begin
        wr_seen_b++;
        if (exp_wr_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_write: got addr=%0d data=%0h, expected no write", b_wr_addr, b_wr_data);
        end else begin
          w = exp_wr_b.pop_front();
          chk("b_wr_addr", b_wr_addr, w.addr);
          chk("b_wr_data", b_wr_data, w.data);
        end
      end
    end
  end

  // Playback monitor: one sample late in every tick interval after btn_play.
  initial begin : play_mon
    int n;
    forever begin
      @(posedge clk iff play_armed);
      repeat (3) @(posedge clk);
      while (exp_play.size() > 0) begin
        #1;
        n = exp_play.pop_front();
        chk("play_note", a_note, n);
        repeat (4) @(posedge clk);
      end
      #1;
      chk("play_end_note", a_note, 0);
      chk("play_end_state", a_state, 0);
      play_done_cnt++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, cur, s0;
    repeat (3) @(negedge clk);
    chk("rst_a_wr_en", a_wr_en, 0);
    chk("rst_a_wr_addr", a_wr_addr, 0);
    chk("rst_a_wr_data", a_wr_data, 0);
    chk("rst_a_rd_addr", a_rd_addr, 0);
    chk("rst_a_note", a_note, 0);
    chk("rst_a_state", a_state, 0);
    chk("rst_a_len", a_len, 0);
    chk("rst_a_full", a_full, 0);
    chk("rst_b_state", b_state, 0);
    chk("rst_b_len", b_len, 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_no_write_a", wr_seen_a, 0);
    chk("idle_no_write_b", wr_seen_b, 0);

    tape = '{1, 1, 1, 2, 2};
    do_record();
    do_play();

    pulse(P_CLEAR);
    chk("clear_a_len", a_len, 0);
    chk("clear_b_len", b_len, 0);
    pulse(P_PLAY);
    repeat (3) @(negedge clk);
    chk("play_empty_a_state", a_state, 0);
    chk("play_empty_b_state", b_state, 0);

    tape = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
    do_record();
    do_play();

    tape = '{1, 2, 3, 4, 5, 6};
    do_record();
    do_play();

    for (int it = 0; it < 10; it++) begin
      tape.delete();
      n = $urandom_range(1, 14);
      cur = $urandom_range(0, 7);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) cur = $urandom_range(0, 7);
        tape.push_back(cur);
      end
      do_record();
      do_play();
    end

    tape = '{3, 3, 3, 3, 3, 4, 4, 4};
    do_record();
    pulse(P_PLAY);
    repeat (10) @(negedge clk);
    pulse(P_STOP | P_PLAY);
    chk("stop_run_a_state", a_state, 0);
    chk("stop_run_a_note", a_note, 0);
    chk("stop_run_b_state", b_state, 0);
    chk("stop_run_b_note", b_note, 0);
    repeat (40) @(negedge clk);
    chk("stop_run_a_stays_idle", a_state, 0);

    s0 = wr_seen_a;
    pulse(P_REC);
    note_in = 3'd6;
    repeat (9) @(negedge clk);
    chk("mid_rec_a_state", a_state, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rec_a_len", a_len, 0);
    chk("mid_rec_a_full", a_full, 0);
    chk("mid_rec_a_state_idle", a_state, 0);
    chk("mid_rec_b_len", b_len, 0);
    repeat (30) @(negedge clk);
    chk("mid_rec_no_write", wr_seen_a, s0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Sequencer for the note record/replay path.
- Captures the encoded note stream into an external run-length note RAM as {note, duration} entries, then replays the entries tick by tick.
- Owns all memory addressing, the 100 Hz timebase, the record length and the mode FSM; the keyboard decoder and the buzzer driver sit on either side of it.

Parameters:
- ADDR_W, 7, RAM address width; depth = 2**ADDR_W entries.
- DUR_W, 10, run-duration width in ticks; saturates at 2**DUR_W-1.
- NOTE_W, 3, encoded note width; code 0 = space/rest.
- TICK_DIV, 1000000, sys_clk cycles per tick (100 Hz from 100 MHz).

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_rec  in  1  one-cycle pulse: start a new recording
- btn_play  in  1  one-cycle pulse: start playback
- btn_stop  in  1  one-cycle pulse: stop record or playback
- btn_clear  in  1  one-cycle pulse: discard the recording
- note_in  in  NOTE_W  live encoded note
- mem_wr_en  out  1  RAM write strobe, one cycle
- mem_wr_addr  out  ADDR_W  RAM write address
- mem_wr_data  out  NOTE_W+DUR_W  {note, dur}
- mem_rd_addr  out  ADDR_W  RAM read address
- mem_rd_data  in  NOTE_W+DUR_W  synchronous read data, valid 1 cycle after address
- note_out  out  NOTE_W  note to buzzer
- state_out  out  2  IDLE=0, REC=1, FETCH=2, RUN=3
- len_out  out  ADDR_W+1  number of valid entries
- full  out  1  recording hit capacity

Behaviour:
- Reset (async, rst_n low): every output and register goes to 0; state goes to IDLE. This applies mid-record or mid-play; the recording is lost (len_out=0).
- Tick: generated internally. The tick counter zeroes on every IDLE->REC and IDLE->FETCH transition, so the first tick arrives exactly TICK_DIV cycles after the button.
- Button priority when several pulse together: stop > clear > rec > play. Buttons that do not apply in the current state are ignored.
- IDLE: note_out=0.
  - btn_clear: len_out=0, wr_ptr=0, full=0.
  - btn_rec: wr_ptr=0, len_out=0, full=0, run_valid=0, enter REC.
  - btn_play: if len_out>0, rd_ptr=0 and enter FETCH; if len_out=0, ignored.
- REC, on each tick, sample note_in:
  - run_valid=0: cur_note=note_in, dur=1, run_valid=1, no write.
  - note_in==cur_note and dur<max: dur+1.
  - Otherwise (note change, or dur saturated): write {cur_note,dur} at wr_ptr, wr_ptr+1, then cur_note=note_in, dur=1. A held note longer than max splits into consecutive entries of the same note.
  - Rests are recorded as note 0 runs.
  - note_out follows note_in combinationally-registered: 1 cycle delay.
- REC, btn_stop: if run_valid, flush the pending run with one write; len_out=final wr_ptr; go to IDLE.
- REC, capacity: when the write to entry 2**ADDR_W-1 occurs, full=1, len_out=2**ADDR_W and the FSM goes to IDLE in the same cycle. The pending new run is dropped; no pointer wrap and no overwrite.
- FETCH: mem_rd_addr=rd_ptr and is held. Next cycle, load note_out=data.note and remain=data.dur, then enter RUN. note_out keeps its previous value through FETCH (2-cycle gap, inaudible).
- RUN, on each tick:
  - remain>1: remain-1.
  - remain==1 and rd_ptr+1==len_out: note_out=0, go to IDLE.
  - remain==1 otherwise: rd_ptr+1, go to FETCH.
- RUN/FETCH, btn_stop: note_out=0, go to IDLE immediately.
- Stored dur=0 cannot occur; if read, it is treated as 1.
- Latency: a run of D ticks replays for exactly D ticks, ±2 sys_clk cycles of fetch slip per entry.
- mem_wr_en is asserted only in REC, on a tick or on a stop flush.

Decomposition:
- Shared constants file holds:
  - state encodings,
  - note codes (space=0, do..si=1..7),
  - default widths.
- One sub-module, tick_gen (TICK_DIV, sys_clk, rst_n, clr, tick), replaces the standalone 100 Hz divider.
- The RAM (note_ram) is a separate instance outside this block.

Test Plan (TICK_DIV=4 unless stated):
- Reset while asserted -> all outputs 0, state_out=0. Release reset, no buttons for 100 cycles -> no mem_wr_en.
- btn_rec; note_in=1 for 3 ticks, then 2 for 2 ticks; btn_stop -> writes addr0={1,3}, addr1={2,2}; len_out=2; state_out=0.
- Then btn_play -> note_out=1 for 3 ticks, then 2 for 2 ticks, then 0; state returns to IDLE; btn_play with len_out=0 -> no state change.
- DUR_W=3: hold note 5 for 9 ticks, stop -> entries {5,7},{5,2}; len_out=2.
- ADDR_W=2: note changes every tick -> after the 4th write, full=1, len_out=4, state IDLE; no 5th write.
- Simultaneous btn_stop+btn_play in RUN -> IDLE, note_out=0. rst_n pulse mid-REC -> len_out=0, full=0, no write.
